// File: rtl/tipi_link_master.sv
// rtl/tipi_link_master.sv - FPGA-side master for the TIPI serial register link
// Drives r_clk/r_cd/r_rt/r_le/r_dout toward the TIPI register block and shifts r_din in.
module tipi_link_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_ctrl,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_abort,
  output logic       busy,
  output logic       r_clk,
  output logic       r_cd,
  output logic       r_rt,
  output logic       r_le,
  output logic       r_dout,
  input  logic       r_din,
  input  logic       r_reset
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE_HI, PULSE_LO, DONE} state_t;

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [3:0]      bit_cnt;
  logic            wr_q;
  logic [7:0]      shreg;
  logic [7:0]      sh_next;
  logic            phase_end;
  logic            in_link;

  // shreg holds the remaining write bits (MSB next) or the read bits gathered so far
  assign sh_next   = {shreg[6:0], r_din};
  assign phase_end = (div_cnt == DIV_LAST);
  assign in_link   = (state == SETUP) || (state == PULSE_HI) || (state == PULSE_LO);
  assign req_ready = (state == IDLE) && r_reset;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= 4'd0;
      wr_q      <= 1'b0;
      shreg     <= 8'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
      rsp_abort <= 1'b0;
      r_clk     <= 1'b0;
      r_cd      <= 1'b0;
      r_rt      <= 1'b0;
      r_le      <= 1'b0;
      r_dout    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (in_link) begin
        div_cnt <= phase_end ? '0 : div_cnt + DW'(1);
      end
      if (in_link && !r_reset) begin
        // link reset from the register block: stop immediately, even mid-high phase
        state     <= DONE;
        rsp_valid <= 1'b1;
        rsp_abort <= 1'b1;
        rsp_rdata <= 8'd0;
        r_clk     <= 1'b0;
        r_cd      <= 1'b0;
        r_rt      <= 1'b0;
        r_le      <= 1'b0;
        r_dout    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid && r_reset) begin
              state   <= SETUP;
              div_cnt <= '0;
              bit_cnt <= 4'd0;
              wr_q    <= req_write;
              shreg   <= {req_wdata[6:0], 1'b0};
              r_rt    <= ~req_write;
              r_cd    <= ~req_ctrl;
              r_le    <= ~req_write;
              r_dout  <= req_write & req_wdata[7];
            end
          end
          SETUP: begin
            if (phase_end) begin
              state <= PULSE_HI;
              r_clk <= 1'b1;
            end
          end
          PULSE_HI: begin
            if (phase_end) begin
              state <= PULSE_LO;
              r_clk <= 1'b0;
              if (!wr_q) begin
                r_le <= 1'b0;
              end else if (bit_cnt < 4'd7) begin
                r_dout <= shreg[7];
                shreg  <= {shreg[6:0], 1'b0};
              end else if (bit_cnt == 4'd7) begin
                r_le   <= 1'b1;
                r_dout <= 1'b0;
              end
            end
          end
          PULSE_LO: begin
            if (phase_end) begin
              // r_din lags one pulse, so the bit loaded by pulse k is sampled here
              if (!wr_q && bit_cnt != 4'd0) begin
                shreg <= sh_next;
              end
              if (bit_cnt == 4'd8) begin
                state     <= DONE;
                rsp_valid <= 1'b1;
                rsp_abort <= 1'b0;
                rsp_rdata <= wr_q ? 8'd0 : sh_next;
                r_cd      <= 1'b0;
                r_rt      <= 1'b0;
                r_le      <= 1'b0;
                r_dout    <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                state   <= PULSE_HI;
                r_clk   <= 1'b1;
              end
            end
          end
          DONE: begin
            state     <= IDLE;
            rsp_abort <= 1'b0;
            rsp_rdata <= 8'd0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tipi_link_master.sv
// tb/tb_tipi_link_master.sv - scoreboard bench for tipi_link_master
// Models the TIPI register block shift source on r_din and checks pins per r_clk pulse.
module tb_tipi_link_master;

  localparam int D  = 4;
  localparam int D2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0, req_write = 1'b0, req_ctrl = 1'b0;
  logic [7:0] req_wdata = 8'd0;
  logic       r_din = 1'b0, r_reset = 1'b1;
  logic       req_ready, rsp_valid, rsp_abort, busy;
  logic [7:0] rsp_rdata;
  logic       r_clk, r_cd, r_rt, r_le, r_dout;

  logic       req2_valid = 1'b0, req2_write = 1'b0, req2_ctrl = 1'b0;
  logic [7:0] req2_wdata = 8'd0;
  logic       r2_din = 1'b0, r2_reset = 1'b1;
  logic       req2_ready, rsp2_valid, rsp2_abort, busy2;
  logic [7:0] rsp2_rdata;
  logic       r2_clk, r2_cd, r2_rt, r2_le, r2_dout;

  tipi_link_master #(.CLK_DIV(D)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_ctrl(req_ctrl), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_abort(rsp_abort), .busy(busy),
    .r_clk(r_clk), .r_cd(r_cd), .r_rt(r_rt), .r_le(r_le), .r_dout(r_dout),
    .r_din(r_din), .r_reset(r_reset)
  );

  tipi_link_master #(.CLK_DIV(D2)) dut2 (
    .clk(clk), .reset_n(reset_n), .req_valid(req2_valid), .req_ready(req2_ready),
    .req_write(req2_write), .req_ctrl(req2_ctrl), .req_wdata(req2_wdata),
    .rsp_valid(rsp2_valid), .rsp_rdata(rsp2_rdata), .rsp_abort(rsp2_abort), .busy(busy2),
    .r_clk(r2_clk), .r_cd(r2_cd), .r_rt(r2_rt), .r_le(r2_le), .r_dout(r2_dout),
    .r_din(r2_din), .r_reset(r2_reset)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // register block source: load on an r_le pulse, otherwise shift out MSB first, one pulse late
  logic [7:0] td_val = 8'hA5, tc_val = 8'h69, td2_val = 8'hC3;
  logic [7:0] src = 8'd0, src2 = 8'd0;
  logic       pm = 1'b0, pm2 = 1'b0;
  always @(negedge clk) begin
    if (r_clk && !pm) begin
      if (r_le) src <= r_cd ? td_val : tc_val;
      else begin
        r_din <= src[7];
        src   <= {src[6:0], 1'b0};
      end
    end
    if (r2_clk && !pm2) begin
      if (r2_le) src2 <= td2_val;
      else begin
        r2_din <= src2[7];
        src2   <= {src2[6:0], 1'b0};
      end
    end
    pm  <= r_clk;
    pm2 <= r2_clk;
  end

  typedef struct {
    logic [7:0] rdata;
    logic       abort;
    logic       wr;
    logic       ctrl;
    logic [7:0] wdata;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  exp_t       e_m;
  logic [3:0] plog[$];
  int         cyc = 0;
  int         rsp_count = 0;
  int         last_rsp_cyc = 0;
  logic       abort_next = 1'b0;
  logic       b2b_mode = 1'b0;
  logic       prev_rclk = 1'b0;
  logic       exp_le, exp_dout;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (r_clk && !prev_rclk) plog.push_back({r_le, r_dout, r_cd, r_rt});
    prev_rclk = r_clk;
    if (req_valid && req_ready) begin
      e_m.wr    = req_write;
      e_m.ctrl  = req_ctrl;
      e_m.wdata = req_wdata;
      e_m.abort = abort_next;
      e_m.rdata = (req_write || abort_next) ? 8'd0 : (req_ctrl ? tc_val : td_val);
      e_m.acc   = cyc;
      if (b2b_mode) check("b2b_gap", cyc - last_rsp_cyc, 1);
      sb.push_back(e_m);
      plog.delete();
    end
    if (rsp_valid) begin
      rsp_count++;
      last_rsp_cyc = cyc;
      check("done_idle_pins", {r_clk, r_le, r_dout, r_rt, r_cd}, 0);
      if (sb.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        e_m = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e_m.rdata);
        check("rsp_abort", rsp_abort, e_m.abort);
        if (!e_m.abort) begin
          check("latency", cyc - e_m.acc, 1 + 19 * D);
          check("rclk_rises", plog.size(), 9);
          for (int k = 0; k < plog.size() && k < 9; k++) begin
            exp_le   = e_m.wr ? (k == 8) : (k == 0);
            exp_dout = (e_m.wr && k < 8) ? e_m.wdata[7-k] : 1'b0;
            check($sformatf("pulse%0d_pins", k), plog[k], {exp_le, exp_dout, ~e_m.ctrl, ~e_m.wr});
          end
        end
      end
    end
  end

  task automatic wait_accept(input bit hold);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 300);
    if (!req_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic send(input logic wr, input logic ctrl, input logic [7:0] wd, input bit hold);
    @(posedge clk);
    #1;
    req_write = wr;
    req_ctrl  = ctrl;
    req_wdata = wd;
    req_valid = 1'b1;
    wait_accept(hold);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("rsp_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  int  cnt0, c2, run, n2;
  logic p2, fin2;

  initial begin
    #1;
    check("reset_outputs", {rsp_valid, rsp_rdata, rsp_abort, busy, r_clk, r_cd, r_rt, r_le, r_dout}, 0);
    check("reset_ready", req_ready, 1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    send(1'b0, 1'b0, 8'h00, 1'b0);             // read TD
    wait_idle();
    send(1'b1, 1'b1, 8'h3C, 1'b0);             // write RC
    wait_idle();

    send(1'b0, 1'b1, 8'h00, 1'b1);             // read TC, valid held into write RD
    b2b_mode  = 1'b1;
    req_write = 1'b1;
    req_ctrl  = 1'b0;
    req_wdata = 8'hFF;
    wait_accept(1'b0);
    b2b_mode = 1'b0;
    wait_idle();

    abort_next = 1'b1;                         // link reset during pulse 4 of a read
    send(1'b0, 1'b0, 8'h00, 1'b0);
    abort_next = 1'b0;
    n2 = 0;
    while (plog.size() < 5 && n2 < 300) begin
      @(posedge clk);
      #2;
      n2++;
    end
    r_reset = 1'b0;
    wait_idle();
    req_write = 1'b0;
    req_ctrl  = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ready_in_link_reset", req_ready, 0);
    end
    @(posedge clk);
    #1 r_reset = 1'b1;
    wait_accept(1'b0);
    wait_idle();

    send(1'b1, 1'b1, 8'h96, 1'b0);             // reset_n mid-write
    repeat (30) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {rsp_valid, rsp_rdata, rsp_abort, busy, r_clk, r_cd, r_rt, r_le, r_dout}, 0);
    check("async_reset_ready", req_ready, 1);
    sb.delete();
    cnt0 = rsp_count;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (100) @(posedge clk);
    check("no_rsp_after_reset", rsp_count - cnt0, 0);
    send(1'b0, 1'b0, 8'h00, 1'b0);
    wait_idle();

    @(posedge clk);                            // CLK_DIV=2 read on the second instance
    #1 req2_valid = 1'b1;
    n2 = 0;
    do begin
      @(negedge clk);
      n2++;
    end while (!req2_ready && n2 < 50);
    c2  = cyc;
    p2  = 1'b0;
    run = 0;
    fin2 = 1'b0;
    @(posedge clk);
    #1 req2_valid = 1'b0;
    n2 = 0;
    while (!fin2 && n2 < 200) begin
      @(negedge clk);
      n2++;
      if (rsp2_valid) begin
        fin2 = 1'b1;
        check("div2_latency", cyc - c2, 1 + 19 * D2);
        check("div2_rdata", rsp2_rdata, td2_val);
        check("div2_abort", rsp2_abort, 0);
        check("div2_idle_pins", {r2_clk, r2_cd, r2_rt, r2_le, r2_dout}, 0);
      end else begin
        if (r2_clk !== p2) begin
          check("div2_phase_len", run, D2);
          run = 1;
        end else run++;
        p2 = r2_clk;
      end
    end
    if (!fin2) check("div2_timeout", 0, 1);
    @(negedge clk);
    check("div2_idle_busy", busy2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/tipi_link_master.md
Name: tipi_link_master

Overview:
- FPGA-side master for the TIPI serial register link. It stands in for the RPi side and drives the r_clk/r_cd/r_rt/r_le/r_dout pins of the TIPI register block; it samples r_din.
- A simple request/response port lets an on-chip client do two things:
  - read the TI-written TD/TC latches;
  - write the RD/RC registers that the TI reads back.
- It sits directly downstream/upstream of the TIPI register block, on its r_* interface.

Parameters:
- CLK_DIV, 4: clk cycles per r_clk half-period. Legal values are ≥2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a cycle where req_valid&req_ready.
- req_write  in  1  0=read TD/TC, 1=write RD/RC.
- req_ctrl  in  1  0=data register (TD/RD), 1=control register (TC/RC).
- req_wdata  in  8  write byte, [7] is the MSB.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read byte; 0 for writes and aborts.
- rsp_abort  out  1  qualifies rsp_valid; the transaction was aborted.
- busy  out  1  high while not IDLE.
- r_clk  out  1  link shift clock.
- r_cd  out  1  register select: 1=data, 0=control.
- r_rt  out  1  direction: 1=TI-originated (TD/TC), 0=RPi-originated (RD/RC).
- r_le  out  1  load/latch enable.
- r_dout  out  1  serial data to RD/RC.
- r_din  in  1  serial data from TD/TC; its source is registered on r_clk.
- r_reset  in  1  active-low link reset from the TIPI register block.

Behaviour:
- Reset (reset_n=0, asynchronous) forces state IDLE and sets every output to 0 except req_ready. req_ready then follows IDLE&r_reset.
- Idle pin levels: r_clk=0, r_le=0, r_dout=0, r_rt=0, r_cd=0.
- Acceptance rule: req_ready=1 only in IDLE with r_reset=1.
  - Request fields are captured on the accept edge. Later changes to req_* are ignored.
- States: IDLE -> SETUP -> PULSE_HI <-> PULSE_LO (9 pulses, counted 0..8) -> DONE -> IDLE.
- Phase lengths: SETUP, each PULSE_HI and each PULSE_LO last CLK_DIV clk cycles.
  - r_clk=1 only in PULSE_HI.
- Entering SETUP sets the select pins:
  - r_rt=~req_write;
  - r_cd=~req_ctrl, i.e. data=1, control=0.
  - r_rt/r_cd are held constant until DONE.
- r_le and r_dout change only on the first cycle of SETUP or PULSE_LO. This gives ≥CLK_DIV cycles of setup before every r_clk rise.
- Read sequence (req_write=0):
  - Pulse 0 is the load pulse, with r_le=1 during SETUP and pulse 0. r_le drops at the start of pulse 0's LO phase.
  - Pulses 1..8 are shift pulses, with r_le=0.
  - r_din is sampled on the last clk cycle of PULSE_LO of pulse k (k=1..8). This accounts for the one-pulse delay of the registered r_din source.
  - Sample k goes to bit 8-k, so MSB first.
- Write sequence (req_write=1):
  - Pulses 0..7 shift, with r_le=0. r_dout = wdata[7-k] is valid before pulse k: set in SETUP for k=0, otherwise in the preceding PULSE_LO.
  - Pulse 8 is the latch pulse. r_le=1 from the start of pulse 7's LO phase through pulse 8; r_dout=0.
- DONE (one cycle):
  - rsp_valid=1, rsp_abort=0, rsp_rdata = assembled byte (reads) or 0 (writes).
  - All r_* outputs return to idle levels in this cycle.
- Latency: rsp_valid is high exactly 1+19*CLK_DIV cycles after the accept edge (77 for CLK_DIV=4).
- Back-to-back: the earliest next accept is the cycle after DONE.
- No backpressure on the response. rsp_valid is a pulse and is never held.
- Abort: if r_reset=0 in any state other than IDLE or DONE:
  - the next cycle enters DONE with rsp_abort=1, rsp_rdata=0;
  - r_* outputs go idle that same cycle;
  - no further r_clk edges occur, and a truncated r_clk high phase is permitted.
- req_valid while r_reset=0: the request is not accepted and waits.
- reset_n asserted mid-transaction: immediate idle, no rsp_valid.
- Bit counter: 4 bits, never wraps past 8. There are exactly 9 rising r_clk edges per complete transaction.

Test Plan:
- Read TD: req_write=0, req_ctrl=0, CLK_DIV=4; r_din model delivers 1,0,1,0,0,1,0,1 after pulses 1..8.
  - Expect r_rt=1, r_cd=1, r_le=1 only through pulse 0, 9 r_clk rises.
  - Expect rsp_rdata=0xA5, rsp_valid at accept+77.
- Write RC 0x3C: r_dout before pulses 0..7 = 0,0,1,1,1,1,0,0; r_le=1 on pulse 8 only; r_rt=0, r_cd=0; rsp_valid with rsp_rdata=0x00.
- Read TC followed by write RD 0xFF, req_valid held high:
  - second accept occurs the cycle after the first DONE;
  - TC read shows r_cd=0; RD write shows r_cd=1 and eight 1-bits on r_dout.
- r_reset=0 during pulse 4 of a read:
  - the next cycle gives rsp_valid=1, rsp_abort=1, rsp_rdata=0, r_clk=0;
  - req_ready stays 0 until r_reset returns to 1.
- reset_n pulsed low mid-write: all outputs 0 asynchronously; no rsp_valid; a new request afterwards completes normally.
- CLK_DIV=2 read: rsp_valid at accept+39; every r_clk high and low phase lasts exactly 2 cycles.
